uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ on-chip requesters, for example an APB software path and a DMA path.
- Captures one data frame from the winning requester and drives the transmitter's tx_data / start_tx inputs.
- Waits for the transmitter's completion indication, then signals done to the owner and rotates priority.
- Sits between requester logic and the UART TX datapath, alongside the register block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, frame payload width (5..32).
- TIMEOUT_CYC, 65535, cycles to wait in WAIT_DONE before abort. Used only with UART_TX_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous reset, active-low
- req_i  input  NUM_REQ  per-requester request level; held until gnt_o for that bit
- req_data_i  input  NUM_REQ*DATA_W  payloads; slice k = bits [k*DATA_W +: DATA_W]
- gnt_o  output  NUM_REQ  one-hot, one-cycle pulse: payload captured
- done_o  output  NUM_REQ  one-hot, one-cycle pulse: frame finished or aborted
- start_tx_o  output  1  one-cycle start pulse to the UART transmitter
- tx_data_o  output  DATA_W  captured payload; stable from LAUNCH until return to IDLE
- tx_done_i  input  1  transmitter completion flag (level or pulse)
- busy_o  output  1  high in every state except IDLE
- owner_o  output  $clog2(NUM_REQ)  index of the current or last granted requester
- timeout_o  output  1  one-cycle pulse on abort; constant 0 when the feature is excluded

Behaviour:
- Reset values: state=IDLE, gnt_o=0, done_o=0, start_tx_o=0, tx_data_o=0, busy_o=0, owner_o=NUM_REQ-1 (so requester 0 wins first), timeout_o=0, tx_done_q=0. Reset mid-frame aborts immediately; no done_o is issued.
- Completion event = tx_done_i & ~tx_done_q, where tx_done_q is tx_done_i registered every cycle. A level left high by a previous frame is never treated as completion.
- FSM: IDLE -> LAUNCH -> WAIT_DONE -> DONE -> IDLE.
- IDLE: at an edge where |req_i, pick the first set bit searching upward from owner_o+1 with modulo NUM_REQ wrap. Load owner_o and tx_data_o from the winner's slice, set gnt_o[winner]=1, go to LAUNCH. Requests that rise in the same cycle are treated identically; only the round-robin pointer decides.
- LAUNCH (1 cycle): gnt_o and start_tx_o both high. Next edge clears them and goes to WAIT_DONE.
- Latency: req sampled at edge N -> gnt_o and start_tx_o high in cycle N+1.
- WAIT_DONE: hold until a completion event, then go to DONE. req_i changes are ignored. A completion event seen in the LAUNCH cycle is ignored, so the edge register must have observed tx_done_i low first.
- DONE (1 cycle): done_o[owner_o]=1. Next edge returns to IDLE.
- Back-to-back: a requester holding req_i may be re-granted no earlier than 4 cycles after its previous gnt_o, and only if no other requester is pending.
- The requester de-asserting req_i before gnt_o is legal: that request is withdrawn. Any de-assertion after gnt_o is ignored.
- owner_o is held between frames and is never modified outside the IDLE grant.
- Fairness: with all NUM_REQ requests held high continuously, grants cycle 0,1,..,NUM_REQ-1,0.

Optional Feature:
- Macro UART_TX_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYC+1) clears on entry to WAIT_DONE and increments each cycle there. When it reaches TIMEOUT_CYC with no completion event: timeout_o=1 for one cycle, then go to DONE (done_o[owner] still pulses in the following cycle), and priority rotates normally.
- Not defined: no counter is built, timeout_o is tied 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then req_i=4'b0100 with slice2=8'hA5 -> gnt_o=4'b0100 and start_tx_o=1 one cycle later, tx_data_o=8'hA5. Pulse tx_done_i 10 cycles later -> done_o=4'b0100 one cycle after WAIT_DONE sees the edge; busy_o falls.
- req_i=4'b1111 held, tx_done_i pulsed per frame -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; owner_o = 0,1,2,3,0.
- tx_done_i held high across two frames -> the second frame stays in WAIT_DONE until tx_done_i drops and rises again; no early done_o.
- req_i=4'b0001 dropped in the same cycle req_i[3] rises, after owner_o=2 -> grant goes to requester 3, requester 0 receives no gnt_o.
- reset_n asserted in WAIT_DONE -> all outputs 0 and owner_o=3 asynchronously; next request from requester 1 is granted normally.
- With UART_TX_TIMEOUT_EN and TIMEOUT_CYC=20, no tx_done_i -> timeout_o pulses 20 cycles after WAIT_DONE entry, done_o pulses, the next pending requester is granted. Without the macro, same stimulus -> busy_o stays 1 indefinitely and timeout_o stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Optional WAIT_DONE abort timer is built when UART_TX_TIMEOUT_EN is defined.
// State table:
//   S_IDLE      | no frame in flight; grant the next requester round-robin
//   S_LAUNCH    | gnt_o and start_tx_o pulse for one cycle
//   S_WAIT_DONE | waiting for a tx_done_i rising edge (or timeout)
//   S_DONE      | done_o pulse to the owner, then back to S_IDLE
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       start_tx_o,
  output logic [DATA_W-1:0]          tx_data_o,
  input  logic                       tx_done_i,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic [DATA_W-1:0]  r_tx_data;
  logic [DATA_W-1:0]  w_win_data;
  logic               r_tx_done_q;
  logic               w_tx_done_evt;
  logic               w_timeout;

  assign w_tx_done_evt = tx_done_i & ~r_tx_done_q;

  // Search upward from the slot after the last owner, wrapping modulo NUM_REQ.
  always_comb begin : rr_pick
    logic [IDX_W-1:0] v_idx;
    v_idx    = '0;
    w_found  = 1'b0;
    w_winner = r_owner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = IDX_W'((int'(r_owner) + k) % NUM_REQ);
      if (!w_found && req_i[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_winner == IDX_W'(k)) begin
        w_win_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    gnt_o       = '0;
    done_o      = '0;
    start_tx_o  = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_found) begin
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        gnt_o[r_owner] = 1'b1;
        start_tx_o     = 1'b1;
        w_state_nxt    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_tx_done_evt || w_timeout) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_o[r_owner] = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        busy_o      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= IDX_W'(NUM_REQ - 1);
      r_tx_data   <= '0;
      r_tx_done_q <= 1'b0;
    end else begin
      r_tx_done_q <= tx_done_i;
      if (r_state == S_IDLE && w_found) begin
        r_owner   <= w_winner;
        r_tx_data <= w_win_data;
      end
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;

  // Saturates at the limit; cleared in LAUNCH so each WAIT_DONE starts at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT_DONE && r_to_cnt != TO_W'(TIMEOUT_CYC)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT_DONE) &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC)) && !w_tx_done_evt;
`else
  assign w_timeout = 1'b0;
`endif

  assign timeout_o = w_timeout;
  assign tx_data_o = r_tx_data;
  assign owner_o   = r_owner;

endmodule
